// File: rtl/data_types_pkg.sv
// Shared types for the UART transmit path: transmitter config and arbiter states.
package data_types_pkg;

    localparam int unsigned DATA_W   = 9;
    localparam int unsigned BR_DIV_W = 16;

    // word: 0 = 8-bit, 1 = 9-bit frame; stop: 0 = one, 1 = two stop bits
    typedef struct packed {
        logic                word;
        logic                stop;
        logic [BR_DIV_W-1:0] br_div;
    } config_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CFG,
        ARB_SEND,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    import data_types_pkg::*;

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    config_t [N_REQ-1:0]     req_cfg;
    logic [N_REQ-1:0]        ack;
    logic                    ack_err;
    logic                    busy;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    tx_rst;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    config_t                 tx_cfg;
    logic                    tx_finish;

    // Arbiter side
    modport master (
        input  req, req_data, req_cfg, tx_finish,
        output ack, ack_err, busy, gnt_idx, tx_rst, tx_start, tx_data, tx_cfg
    );

    // Requesters plus transmitter side
    modport slave (
        output req, req_data, req_cfg, tx_finish,
        input  ack, ack_err, busy, gnt_idx, tx_rst, tx_start, tx_data, tx_cfg
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational rotate-priority encoder: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan ptr+1 .. ptr+N (mod N); the first hit wins
    always_comb begin
        int unsigned pos;
        logic [IW-1:0] p;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        pos        = 0;
        p          = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            p = IW'(pos);
            if (!any && req[p]) begin
                any           = 1'b1;
                gnt_idx       = p;
                gnt_onehot[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ requesters, with watchdog.
module uart_tx_arbiter
    import data_types_pkg::*;
#(
    parameter int unsigned     N_REQ   = 4,
    parameter int unsigned     TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = TO_W'(16'hFFFF)
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int unsigned     IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - TO_W'(1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0]  gnt_oh_q, gnt_oh_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              ack_err_q, ack_err_d;
    logic              busy_q, busy_d;
    logic              tx_rst_q, tx_rst_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    config_t           tx_cfg_q, tx_cfg_d;
    logic [TO_W-1:0]   wd_q, wd_d;

    logic [N_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] words [N_REQ];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (bus.req),
        .ptr        (ptr_q),
        .gnt_onehot (arb_oh),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // Unpack requester words for indexed selection
    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_oh_d   = gnt_oh_q;
        ack_d      = '0;
        ack_err_d  = 1'b0;
        tx_rst_d   = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_cfg_d   = tx_cfg_q;
        wd_d       = wd_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_any) begin
                    state_d   = ARB_CFG;
                    gnt_idx_d = arb_idx;
                    gnt_oh_d  = arb_oh;
                    tx_data_d = words[arb_idx];
                    tx_cfg_d  = bus.req_cfg[arb_idx];
                    tx_rst_d  = 1'b1;
                end
            end
            ARB_CFG: begin
                state_d    = ARB_SEND;
                tx_start_d = 1'b1;
            end
            ARB_SEND: begin
                state_d = ARB_WAIT;
                wd_d    = '0;
            end
            ARB_WAIT: begin
                if (bus.tx_finish) begin
                    state_d = ARB_DONE;
                    ack_d   = gnt_oh_q;
                end else if (wd_q == WD_LAST) begin
                    state_d   = ARB_DONE;
                    ack_d     = gnt_oh_q;
                    ack_err_d = 1'b1;
                    tx_rst_d  = 1'b1;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                ptr_d   = gnt_idx_q;
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            gnt_idx_q  <= '0;
            gnt_oh_q   <= '0;
            ack_q      <= '0;
            ack_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_rst_q   <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tx_cfg_q   <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_oh_q   <= gnt_oh_d;
            ack_q      <= ack_d;
            ack_err_q  <= ack_err_d;
            busy_q     <= busy_d;
            tx_rst_q   <= tx_rst_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_cfg_q   <= tx_cfg_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.tx_rst   = tx_rst_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_cfg   = tx_cfg_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: main instance with default watchdog, second with TIMEOUT=8.
module tb_uart_tx_arbiter;
    import data_types_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    uart_tx_arbiter_if #(.N_REQ(4)) m ();
    uart_tx_arbiter_if #(.N_REQ(4)) w ();

    uart_tx_arbiter #(.N_REQ(4), .TO_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    uart_tx_arbiter #(.N_REQ(4), .TO_W(16), .TIMEOUT(16'd8)) dut_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w)
    );

    localparam config_t CFG0 = config_t'{word: 1'b0, stop: 1'b0, br_div: 16'd434};
    localparam config_t CFG1 = config_t'{word: 1'b0, stop: 1'b1, br_div: 16'd217};
    localparam config_t CFG2 = config_t'{word: 1'b1, stop: 1'b0, br_div: 16'd868};
    localparam config_t CFG3 = config_t'{word: 1'b1, stop: 1'b1, br_div: 16'd54};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        m.req       = '0;
        w.req       = '0;
        m.tx_finish = 1'b0;
        w.tx_finish = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // Called at the IDLE negedge where req is already presented; returns at the following IDLE negedge
    task automatic xfer(input string tag, input int unsigned idx, input logic [8:0] data,
                        input config_t cfg, input int unsigned fin, input logic [3:0] req_after);
        step();
        check({tag, ".cfg_rst"}, 32'(m.tx_rst), 32'd1);
        check({tag, ".busy"}, 32'(m.busy), 32'd1);
        check({tag, ".gnt_idx"}, 32'(m.gnt_idx), 32'(idx));
        check({tag, ".tx_data"}, 32'(m.tx_data), 32'(data));
        check({tag, ".tx_cfg"}, 32'(m.tx_cfg), 32'(cfg));
        step();
        check({tag, ".start"}, 32'(m.tx_start), 32'd1);
        check({tag, ".send_rst"}, 32'(m.tx_rst), 32'd0);
        step();
        check({tag, ".start_pulse"}, 32'(m.tx_start), 32'd0);
        repeat (fin - 1) step();
        check({tag, ".no_early_ack"}, 32'(m.ack), 32'd0);
        m.tx_finish = 1'b1;
        step();
        check({tag, ".ack"}, 32'(m.ack), 32'd1 << idx);
        check({tag, ".ack_err"}, 32'(m.ack_err), 32'd0);
        check({tag, ".data_hold"}, 32'(m.tx_data), 32'(data));
        m.tx_finish = 1'b0;
        m.req       = req_after;
        step();
        check({tag, ".ack_clr"}, 32'(m.ack), 32'd0);
        check({tag, ".idle"}, 32'(m.busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m.req = '0; w.req = '0; m.tx_finish = 1'b0; w.tx_finish = 1'b0;
        m.req_data = {9'h1C3, 9'h0A5, 9'h033, 9'h101};
        w.req_data = {9'h1C3, 9'h0A5, 9'h033, 9'h101};
        m.req_cfg  = {CFG3, CFG2, CFG1, CFG0};
        w.req_cfg  = {CFG3, CFG2, CFG1, CFG0};

        // 1: reset with all requests pending
        m.req = 4'b1111;
        repeat (3) step();
        check("s1.rst_tx_rst", 32'(m.tx_rst), 32'd1);
        check("s1.rst_ack", 32'(m.ack), 32'd0);
        check("s1.rst_busy", 32'(m.busy), 32'd0);
        check("s1.rst_start", 32'(m.tx_start), 32'd0);
        check("s1.rst_data", 32'(m.tx_data), 32'd0);
        rst_n = 1'b1;
        xfer("s1", 0, 9'h101, CFG0, 3, 4'b0000);

        // 2: single requester 2
        m.req = 4'b0100;
        xfer("s2", 2, 9'h0A5, CFG2, 18, 4'b0000);

        // 3: round-robin order from reset pointer
        do_reset();
        m.req = 4'b1011;
        xfer("s3a", 0, 9'h101, CFG0, 10, 4'b1011);
        xfer("s3b", 1, 9'h033, CFG1, 10, 4'b1011);
        xfer("s3c", 3, 9'h1C3, CFG3, 10, 4'b1011);
        xfer("s3d", 0, 9'h101, CFG0, 10, 4'b0000);

        // 4: watchdog abort after 8 WAIT cycles
        do_reset();
        w.req = 4'b0001;
        step();
        check("s4.cfg_rst", 32'(w.tx_rst), 32'd1);
        step();
        check("s4.start", 32'(w.tx_start), 32'd1);
        repeat (8) step();
        check("s4.no_ack_yet", 32'(w.ack), 32'd0);
        check("s4.busy", 32'(w.busy), 32'd1);
        step();
        check("s4.ack", 32'(w.ack), 32'd1);
        check("s4.ack_err", 32'(w.ack_err), 32'd1);
        check("s4.done_rst", 32'(w.tx_rst), 32'd1);
        w.req = '0;
        step();
        check("s4.ack_clr", 32'(w.ack), 32'd0);
        check("s4.idle_rst", 32'(w.tx_rst), 32'd0);
        check("s4.idle", 32'(w.busy), 32'd0);

        // 5a: finish on the timeout cycle wins
        w.req = 4'b0001;
        repeat (10) step();
        w.tx_finish = 1'b1;
        step();
        check("s5a.ack", 32'(w.ack), 32'd1);
        check("s5a.ack_err", 32'(w.ack_err), 32'd0);
        check("s5a.done_rst", 32'(w.tx_rst), 32'd0);
        w.tx_finish = 1'b0;
        w.req       = '0;
        step();

        // 5b: req dropped and data changed during WAIT
        w.req = 4'b0100;
        repeat (4) step();
        w.req = '0;
        w.req_data[18 +: 9] = 9'h1FF;
        step();
        check("s5b.data_latched", 32'(w.tx_data), 32'h0A5);
        check("s5b.no_ack_yet", 32'(w.ack), 32'd0);
        w.tx_finish = 1'b1;
        step();
        check("s5b.ack", 32'(w.ack), 32'b0100);
        check("s5b.ack_err", 32'(w.ack_err), 32'd0);
        w.tx_finish = 1'b0;
        w.req_data[18 +: 9] = 9'h0A5;
        step();
        check("s5b.ack_clr", 32'(w.ack), 32'd0);

        // 6: reset during WAIT, then a clean rerun
        m.req = 4'b0100;
        repeat (4) step();
        check("s6.in_wait", 32'(m.busy), 32'd1);
        rst_n = 1'b0;
        step();
        check("s6.rst_tx_rst", 32'(m.tx_rst), 32'd1);
        check("s6.rst_busy", 32'(m.busy), 32'd0);
        check("s6.rst_ack", 32'(m.ack), 32'd0);
        m.req = '0;
        step();
        step();
        check("s6.rst_ack_hold", 32'(m.ack), 32'd0);
        rst_n = 1'b1;
        m.req = 4'b0100;
        xfer("s6", 2, 9'h0A5, CFG2, 18, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
